// File: rtl/uart_recv.sv
// -----------------------------------------------------------------------------
// uart_recv -- 8N1 UART receiver (1 start, 8 data LSB first, 1 stop, no parity)
//
// Counterpart of the board UART transmitter; both ends share CLK_FREQ/UART_BPS.
// The RXD pin is synchronised, a falling edge starts a frame, and every bit is
// decided by a 3-sample majority vote around the bit centre.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   uart_rxd   asynchronous serial input, idle high
//   rx_data    last correctly received byte
//   rx_done    one-cycle pulse: rx_data was updated this cycle
//   frame_err  one-cycle pulse: stop bit sampled low, rx_data not updated
//   rx_busy    high while a frame is being received
//
// BPS_CNT (clocks per bit) must be at least 8 so that the sample window
// (HALF-1 .. HALF+1) lies strictly inside the bit and before BPS_CNT-1.
// -----------------------------------------------------------------------------
module uart_recv #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int UART_BPS = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int HALF    = BPS_CNT / 2;

  localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_PRE  = 16'(HALF - 1);
  localparam logic [15:0] CNT_MID  = 16'(HALF);
  localparam logic [15:0] CNT_DEC  = 16'(HALF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detector
  // ---------------------------------------------------------------------------
  logic rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic fall_edge;

  // NOTE: sequential state is always assigned with non-blocking (<=) so every
  // flop samples the values from before the clock edge; blocking assignments
  // here would collapse the three-flop chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the chain resets to the idle-line level (1), not 0, so leaving
      // reset cannot manufacture a falling edge and a phantom start bit.
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_s3_q <= 1'b1;
    end else begin
      rxd_s1_q <= uart_rxd;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
    end
  end

  assign fall_edge = rxd_s3_q & ~rxd_s2_q;

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [1:0]  samp_q;       // first two votes of the majority window
  logic [7:0]  rx_data_q;
  logic        rx_done_q;
  logic        frame_err_q;
  logic        rx_busy_q;

  logic        bit_val;      // majority of the three votes, valid at CNT_DEC
  logic        at_decide;
  logic        at_last;
  logic [15:0] cnt_wrap;     // clk_cnt_q + 1, wrapping at the end of a bit

  assign bit_val   = (samp_q[0] & samp_q[1]) |
                     (samp_q[0] & rxd_s2_q)  |
                     (samp_q[1] & rxd_s2_q);
  assign at_decide = (clk_cnt_q == CNT_DEC);
  assign at_last   = (clk_cnt_q == CNT_LAST);
  assign cnt_wrap  = at_last ? 16'd0 : clk_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      samp_q      <= 2'b11;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      // Busy is a registered copy of "not idle": it follows the state by one
      // clock, rising 4 clk after the pin edge and falling just after mid-stop.
      rx_busy_q   <= (state_q != IDLE);

      // Gather the first two votes of the window in every active state.
      if (state_q != IDLE) begin
        if (clk_cnt_q == CNT_PRE) samp_q[0] <= rxd_s2_q;
        if (clk_cnt_q == CNT_MID) samp_q[1] <= rxd_s2_q;
      end

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          // Only an edge starts a frame: a line stuck low (break) is ignored
          // until it has gone high and fallen again.
          if (fall_edge) state_q <= START;
        end

        START: begin
          if (at_decide && bit_val) begin
            // Line was high again at the start-bit centre: a glitch, not a frame.
            state_q   <= IDLE;
            clk_cnt_q <= '0;
          end else begin
            clk_cnt_q <= cnt_wrap;
            if (at_last) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
        end

        DATA: begin
          clk_cnt_q <= cnt_wrap;
          if (at_decide) shift_q[bit_cnt_q] <= bit_val;
          if (at_last) begin
            if (bit_cnt_q == 3'd7) state_q <= STOP;
            else                   bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end

        STOP: begin
          clk_cnt_q <= cnt_wrap;
          // Leave at the stop-bit centre so a start bit that follows directly
          // on the stop bit still finds the receiver in IDLE for its edge.
          if (at_decide) begin
            if (bit_val) begin
              rx_data_q <= shift_q;
              rx_done_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q   <= IDLE;
            clk_cnt_q <= '0;
          end
        end

        default: begin
          state_q   <= IDLE;
          clk_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// -----------------------------------------------------------------------------
// tb_uart_recv -- self-checking bench for uart_recv.
// A serial driver emits frames bit by bit and queues the expected outcome of
// each frame (good byte or framing error); an independent monitor pops the
// queue whenever rx_done or frame_err fires and compares.
// -----------------------------------------------------------------------------
module tb_uart_recv;

  localparam int BIT_CLKS = 40;

  logic       clk;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  uart_recv #(
    .CLK_FREQ(100_000_000),
    .UART_BPS(2_500_000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rxd (uart_rxd),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual,
               expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] last_good = 8'h00;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         busy_rises = 0;
  int         busy_rise_cyc = 0;
  int         busy_fall_cyc = 0;
  logic       busy_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic       err_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_good = 8'h00;
      busy_prev = 1'b0;
      done_prev = 1'b0;
      err_prev  = 1'b0;
    end else begin
      if (rx_busy && !busy_prev) begin
        busy_rises++;
        busy_rise_cyc = cyc;
      end
      if (!rx_busy && busy_prev) busy_fall_cyc = cyc;
      busy_prev = rx_busy;

      if (rx_done || frame_err) begin
        check("done_err_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
        check("pulse_width", {31'd0, (rx_done & done_prev) | (frame_err & err_prev)}, 32'd0);
        check("event_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_kind_err", {31'd0, frame_err}, {31'd0, e.err});
          if (e.err) begin
            check("rx_data_hold_on_err", {24'd0, rx_data}, {24'd0, last_good});
          end else begin
            check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            last_good = e.data;
          end
        end
        if (rx_done) done_cnt++;
        if (frame_err) err_cnt++;
      end
      done_prev = rx_done;
      err_prev  = frame_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial driver
  // ---------------------------------------------------------------------------
  int start_cyc = 0;

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 uart_rxd = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 uart_rxd = 1'b0;
    end
  endtask

  // Sends one frame of bclk clocks per bit. gbit >= 0 inverts the line for one
  // clock at the centre of that data bit. abort_at >= 0 stops driving after that
  // many clocks (no expectation is queued for an aborted frame). The line is
  // left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                            input int bclk, input int gbit, input int abort_at);
    int n;
    logic v;
    n = 0;
    if (abort_at < 0) begin
      exp_t e;
      e.err  = !stop_bit;
      e.data = b;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_bit;
      else             v = b[i-1];
      for (int c = 0; c < bclk; c++) begin
        if (abort_at >= 0 && n == abort_at) return;
        @(posedge clk);
        #1;
        if (n == 0) start_cyc = cyc;
        uart_rxd = (gbit >= 0 && i == gbit + 1 && c == bclk / 2) ? ~v : v;
        n++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int d0, e0, r0;
    rst_n    = 1'b0;
    uart_rxd = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    #1 rst_n = 1'b1;
    idle(50);

    // Single frame 0xA5.
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, BIT_CLKS, -1, -1);
    idle(60);
    check("a5_done_count", done_cnt - d0, 32'd1);
    check("a5_err_count", err_cnt - e0, 32'd0);
    check("a5_busy_rise_latency", busy_rise_cyc - start_cyc, 32'd4);
    check("a5_busy_fall_in_stop",
          {31'd0, (busy_fall_cyc - start_cyc >= 9 * BIT_CLKS) &&
                  (busy_fall_cyc - start_cyc <  10 * BIT_CLKS)}, 32'd1);

    // Back-to-back 0x00 then 0xFF.
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h00, 1'b1, BIT_CLKS, -1, -1);
    send_frame(8'hFF, 1'b1, BIT_CLKS, -1, -1);
    idle(60);
    check("b2b_done_count", done_cnt - d0, 32'd2);
    check("b2b_err_count", err_cnt - e0, 32'd0);

    // False start: 10 clocks low.
    d0 = done_cnt; e0 = err_cnt; r0 = busy_rises;
    hold_low(10);
    idle(100);
    check("false_start_busy_pulse", busy_rises - r0, 32'd1);
    check("false_start_busy_low", {31'd0, rx_busy}, 32'd0);
    check("false_start_no_done", done_cnt - d0, 32'd0);
    check("false_start_no_err", err_cnt - e0, 32'd0);
    check("false_start_rx_data", {24'd0, rx_data}, 32'hFF);

    // Bad stop bit, break for 200 clocks, then a valid 0x81.
    d0 = done_cnt; e0 = err_cnt; r0 = busy_rises;
    send_frame(8'h3C, 1'b0, BIT_CLKS, -1, -1);
    hold_low(200);
    check("break_single_busy", busy_rises - r0, 32'd1);
    check("break_err_count", err_cnt - e0, 32'd1);
    check("break_rx_data_held", {24'd0, rx_data}, 32'hFF);
    idle(20);
    send_frame(8'h81, 1'b1, BIT_CLKS, -1, -1);
    idle(60);
    check("break_then_done", done_cnt - d0, 32'd1);

    // One-clock glitch at the centre of bit 2.
    d0 = done_cnt;
    send_frame(8'h55, 1'b1, BIT_CLKS, 2, -1);
    idle(60);
    check("glitch_done_count", done_cnt - d0, 32'd1);
    check("glitch_rx_data", {24'd0, rx_data}, 32'h55);

    // Reset during bit 4 of a frame, then 0x12.
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h77, 1'b1, BIT_CLKS, -1, 5 * BIT_CLKS + 20);
    #1 rst_n = 1'b0;
    uart_rxd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    check("midreset_rx_done", {31'd0, rx_done}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
    #1 rst_n = 1'b1;
    idle(400);
    check("midreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    send_frame(8'h12, 1'b1, BIT_CLKS, -1, -1);
    idle(60);
    check("midreset_then_done", done_cnt - d0, 32'd1);
    check("midreset_rx_data_12", {24'd0, rx_data}, 32'h12);

    // Randomised frames: random data, +/-1 clk per bit baud error, occasional
    // bad stop bit, random idle gaps including none.
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      bit         sb;
      int         bc;
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      bc = BIT_CLKS - 1 + int'($urandom_range(0, 2));
      send_frame(b, sb, bc, -1, -1);
      if (!sb || $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 30)));
    end
    idle(60);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- UART receiver: 8N1 (1 start, 8 data LSB-first, 1 stop), no parity.
- Counterpart of the board UART transmitter; both sides use the same clock and baud parameters.
- Sits between the external RXD pin and the command/control logic.
- Delivers each received byte with a one-cycle done pulse and flags bad stop bits.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- UART_BPS, 2_500_000, baud rate in bit/s.
- BPS_CNT, CLK_FREQ/UART_BPS (=40), clocks per bit, derived localparam; must be >= 8.
- HALF, BPS_CNT/2 (=20), mid-bit count, derived localparam.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset.
- uart_rxd, input, 1, asynchronous serial input; idle high.
- rx_data, output, 8, last correctly received byte.
- rx_done, output, 1, one-cycle pulse: rx_data updated this cycle.
- frame_err, output, 1, one-cycle pulse: stop bit sampled low; rx_data not updated.
- rx_busy, output, 1, high while a frame is being received.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. Reset values:
  - rx_data=0, rx_done=0, frame_err=0, rx_busy=0.
  - Synchronizer flops=1, state=IDLE, clk_cnt=0, bit_cnt=0, shift register=0.
- Reset mid-frame aborts reception with no done or error pulse.
- Input synchronizer: two-flop synchronizer rxd_s1→rxd_s2, plus a third flop rxd_s3 for edge detection.
  - Falling edge = rxd_s3 & ~rxd_s2.
  - Pin-to-edge-detect latency is 3 clk.
- Bit sampling: majority of 3 rxd_s2 values taken at clk_cnt = HALF-1, HALF, HALF+1.
  - The bit is decided at clk_cnt = HALF+1.
  - A single-clock glitch inside the window does not change the bit.
- clk_cnt: 16-bit.
  - Counts 0..BPS_CNT-1 in every non-IDLE state, then wraps to 0.
  - Held at 0 in IDLE.
- State machine:
  - IDLE: rx_busy=0. On falling edge: go to START, clk_cnt=0.
  - START: at the decision point, a majority of 1 is a false start: go to IDLE, no pulses. Otherwise, at clk_cnt=BPS_CNT-1 go to DATA with bit_cnt=0.
  - DATA: at each decision point, shift the bit into position [bit_cnt] (LSB first). At clk_cnt=BPS_CNT-1, bit_cnt+1. After bit_cnt=7 completes, go to STOP.
  - STOP: at the decision point:
    - Majority 1: rx_data<=shift register and rx_done=1 for exactly one cycle.
    - Majority 0: frame_err=1 for one cycle, rx_data holds.
    - Either way, go to IDLE in the same cycle. This releases at mid-stop-bit so a back-to-back start bit is caught.
- rx_busy: registered, high exactly in START, DATA and STOP.
- Line held low after a framing error (break): no new frame starts until the line goes high and then falls again, because start requires a falling edge.
- rx_done and frame_err are never high in the same cycle. Neither is high for more than 1 cycle per frame.
- Falling edges during START/DATA/STOP are ignored; only the sample schedule matters.
- Tolerance: with BPS_CNT=40 the receiver must accept frames with transmitter baud error up to ±3%.

Test Plan:
- Send 0xA5 at 40 clk/bit, idle before and after. Required: exactly one rx_done pulse and rx_data=0xA5. rx_busy rises 4 clk after the start edge and falls at mid-stop. frame_err stays 0.
- Send 0x00 then 0xFF back-to-back (stop bit followed immediately by the next start). Required: two rx_done pulses, rx_data=0x00 then 0xFF, no frame_err.
- Drive uart_rxd low for 10 clk, then high. Required: rx_busy pulses high, returns to IDLE at the START decision, no rx_done, no frame_err, rx_data unchanged.
- Send 0x3C with the stop bit low, then hold low for 200 clk, then a valid 0x81. Required: one frame_err pulse, rx_data unchanged, no spurious frame during the low hold, then rx_done with rx_data=0x81.
- Send 0x55 with a 1-clk inverted glitch at the centre of bit 2. Required: rx_data=0x55, rx_done=1 once.
- Assert rst_n low during bit 4 of a frame, release, then send 0x12. Required: all outputs at reset values during reset, no pulse from the aborted frame, then rx_data=0x12 with one rx_done.
